// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op/state encodings and defaults for the RV32M multiply/divide unit
package muldiv_pkg;

    localparam int MULDIV_DEFAULT_BITS_PER_CYCLE = 2;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } muldivOp_;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } muldivState_;

endpackage

// File: rtl/muldiv_div_step.sv
// muldiv_div_step: BITS_PER_CYCLE restoring-division steps, MSB first, purely combinational
// Ports: rem_i partial remainder, bits_i next dividend bits (MSB first), div_i divisor,
//        rem_o next partial remainder, q_o quotient bits retired this step.
module muldiv_div_step #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 2
) (
    input  logic [XLEN-1:0]           rem_i,
    input  logic [BITS_PER_CYCLE-1:0] bits_i,
    input  logic [XLEN-1:0]           div_i,
    output logic [XLEN-1:0]           rem_o,
    output logic [BITS_PER_CYCLE-1:0] q_o
);

    logic [XLEN:0]   t;
    logic [XLEN-1:0] r;

    // The remainder stays below the divisor, so the shifted value fits XLEN+1 bits
    // and the difference always fits back into XLEN bits.
    always_comb begin
        r   = rem_i;
        t   = '0;
        q_o = '0;
        for (int k = BITS_PER_CYCLE - 1; k >= 0; k--) begin
            t      = {r, bits_i[k]};
            q_o[k] = t >= {1'b0, div_i};
            r      = q_o[k] ? t[XLEN-1:0] - div_i : t[XLEN-1:0];
        end
        rem_o = r;
    end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit beside the execute-stage ALU
// Ports: clock/reset (sync, active-high), flush abandons any op; startValid/startReady
//        accept op/operand1/operand2; resultValid/resultReady hand back result; busy in RUN/DONE.
// Option: define MULDIV_FAST_MUL_EN to compute all multiplies in one combinational cycle.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = MULDIV_DEFAULT_BITS_PER_CYCLE
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    input  logic            startValid,
    output logic            startReady,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] operand1,
    input  logic [XLEN-1:0] operand2,
    output logic            resultValid,
    input  logic            resultReady,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int ITER = XLEN / BITS_PER_CYCLE;
    localparam int CW   = $clog2(ITER + 1);

    muldivState_         state_q, state_d;
    muldivOp_            op_q, op_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     b_q, b_d, result_q, result_d;
    logic                neg_q, neg_d, valid_q, busy_q;

    logic                accept, sgn1, sgn2, divz, ovf, fast, early;
    logic [XLEN-1:0]     mag1, mag2, early_res, fast_res, dstep_rem, quo, rem, fin_res;
    logic [BITS_PER_CYCLE-1:0] dstep_q;
    logic [2*XLEN-1:0]   mul_acc, run_acc, prod;

    assign startReady = (state_q == IDLE || (state_q == DONE && resultReady)) && !flush;
    assign accept     = startValid && startReady;

    // Unsigned forms are MULHU, DIVU, REMU; MULHSU treats only operand2 as unsigned.
    assign sgn1 = operand1[XLEN-1] && !(op[0] && (op[1] || op[2]));
    assign sgn2 = operand2[XLEN-1] && !(op[0] && (op[1] || op[2])) && op != MD_MULHSU;
    assign mag1 = sgn1 ? -operand1 : operand1;
    assign mag2 = sgn2 ? -operand2 : operand2;

    assign divz = op[2] && operand2 == '0;
    assign ovf  = op[2] && !op[0] && operand1 == {1'b1, {(XLEN-1){1'b0}}} && &operand2;

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fprod, fsgn;
    assign fprod    = {{XLEN{1'b0}}, mag1} * {{XLEN{1'b0}}, mag2};
    assign fsgn     = (sgn1 ^ sgn2) ? -fprod : fprod;
    assign fast     = !op[2];
    assign fast_res = op == MD_MUL ? fsgn[XLEN-1:0] : fsgn[2*XLEN-1:XLEN];
`else
    assign fast     = 1'b0;
    assign fast_res = '0;
`endif

    assign early     = divz || ovf || fast;
    assign early_res = divz ? (op[1] ? operand1 : '1) : ovf ? (op[1] ? '0 : operand1) : fast_res;

    // Shift-add: multiplier sits in the low half and drains out as the product fills in.
    always_comb begin
        mul_acc = acc_q;
        for (int k = 0; k < BITS_PER_CYCLE; k++)
            mul_acc = {{1'b0, mul_acc[2*XLEN-1:XLEN]} + (mul_acc[0] ? {1'b0, b_q} : '0), mul_acc[XLEN-1:1]};
    end

    // Division keeps {remainder, dividend} in the accumulator; quotient bits shift in at the bottom.
    muldiv_div_step #(.XLEN(XLEN), .BITS_PER_CYCLE(BITS_PER_CYCLE)) u_div_step (
        .rem_i  (acc_q[2*XLEN-1:XLEN]),
        .bits_i (acc_q[XLEN-1 -: BITS_PER_CYCLE]),
        .div_i  (b_q),
        .rem_o  (dstep_rem),
        .q_o    (dstep_q)
    );

    assign run_acc = op_q[2] ? {dstep_rem, acc_q[XLEN-BITS_PER_CYCLE-1:0], dstep_q} : mul_acc;
    assign prod    = neg_q ? -run_acc : run_acc;
    assign quo     = run_acc[XLEN-1:0];
    assign rem     = run_acc[2*XLEN-1:XLEN];
    assign fin_res = !op_q[2] ? (op_q == MD_MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN])
                   : op_q[1] ? (neg_q ? -rem : rem) : (neg_q ? -quo : quo);

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        b_d      = b_q;
        neg_d    = neg_q;
        result_d = result_q;
        if (flush) begin
            state_d = IDLE;
        end else if (accept) begin
            state_d = early ? DONE : RUN;
            op_d    = muldivOp_'(op);
            cnt_d   = CW'(ITER);
            acc_d   = {{XLEN{1'b0}}, op[2] ? mag1 : mag2};
            b_d     = op[2] ? mag2 : mag1;
            neg_d   = (op[2] && op[1]) ? sgn1 : sgn1 ^ sgn2;
            if (early)
                result_d = early_res;
        end else if (state_q == RUN) begin
            cnt_d = cnt_q - 1'b1;
            acc_d = run_acc;
            if (cnt_q == CW'(1)) begin
                state_d  = DONE;
                result_d = fin_res;
            end
        end else if (state_q == DONE && resultReady) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= MD_MUL;
            cnt_q    <= '0;
            acc_q    <= '0;
            b_q      <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            b_q      <= b_d;
            neg_q    <= neg_d;
            result_q <= result_d;
            valid_q  <= state_d == DONE;
            busy_q   <= state_d != IDLE;
        end
    end

    assign resultValid = valid_q;
    assign result      = result_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit with directed hand-computed vectors
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int MUL_LAT =
`ifdef MULDIV_FAST_MUL_EN
        1;
`else
        17;
`endif

    logic        clock = 1'b0, reset = 1'b1, flush = 1'b0, startValid = 1'b0, resultReady = 1'b1;
    logic        startReady, resultValid, busy;
    logic [2:0]  op = 3'd0;
    logic [31:0] operand1 = '0, operand2 = '0, result;
    int          tests = 0, fails = 0, cyc = 0, a = 0, n = 0;
    bit          seen = 1'b0;

    typedef struct {
        logic [31:0] exp;
        int          lat;
        int          acc;
        string       nm;
    } exp_t;
    exp_t sb[$];

    muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(2)) dut (
        .clock       (clock),
        .reset       (reset),
        .flush       (flush),
        .startValid  (startValid),
        .startReady  (startReady),
        .op          (op),
        .operand1    (operand1),
        .operand2    (operand2),
        .resultValid (resultValid),
        .resultReady (resultReady),
        .result      (result),
        .busy        (busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    // Edge numbers are counted from the accepting edge as edge 0; a value first seen
    // before edge k is reported as edge k.
    always @(negedge clock) begin
        #2;
        if (!reset && resultValid) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_valid: result %h with nothing outstanding", result);
            end else begin
                chk(sb[0].nm, result, sb[0].exp);
                if (!seen)
                    chk({sb[0].nm, "_edge"}, 32'(cyc - sb[0].acc + 1), 32'(sb[0].lat));
                seen = !resultReady;
                if (resultReady)
                    void'(sb.pop_front());
            end
        end
    end

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] e, input int lat, input string nm, input bit track);
        int w = 0;
        @(negedge clock);
        startValid = 1'b1;
        op         = o;
        operand1   = x;
        operand2   = y;
        #1;
        while (!startReady && w < 200) begin
            @(negedge clock);
            #1;
            w++;
        end
        if (!startReady) begin
            tests++;
            fails++;
            $display("FAIL %s_accept: startReady 0 after %0d cycles, 1 required", nm, w);
            startValid = 1'b0;
            return;
        end
        @(posedge clock);
        #1;
        if (track)
            sb.push_back('{e, lat, cyc, nm});
        startValid = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while (sb.size() != 0 && w < 400) begin
            @(negedge clock);
            w++;
        end
        #3;
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d results outstanding, 0 required", sb.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rst_start_ready", 32'(startReady), 32'd1);
        chk("rst_result_valid", 32'(resultValid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_result", result, 32'd0);

        issue(MD_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT, "mul_neg", 1);
        issue(MD_MULH,   32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT, "mulh_min", 1);
        issue(MD_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LAT, "mulhsu", 1);
        issue(MD_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT, "mulhu", 1);
        issue(MD_MUL,    32'd6,        32'd7,        32'h0000002A, MUL_LAT, "mul_pos", 1);
        issue(MD_MULHU,  32'h12345678, 32'h00000010, 32'h00000001, MUL_LAT, "mulhu_small", 1);
        issue(MD_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 17,      "div_neg", 1);
        issue(MD_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 17,      "rem_neg", 1);
        issue(MD_DIVU,   32'hFFFFFFFF, 32'd3,        32'h55555555, 17,      "divu", 1);
        issue(MD_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 17,      "div_negdivisor", 1);
        issue(MD_REM,    32'd7,        32'hFFFFFFFE, 32'h00000001, 17,      "rem_negdivisor", 1);
        issue(MD_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1,       "divu_by0", 1);
        issue(MD_REMU,   32'd5,        32'd0,        32'h00000005, 1,       "remu_by0", 1);
        issue(MD_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,       "div_ovf", 1);
        issue(MD_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1,       "rem_ovf", 1);
        issue(MD_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 1,       "div_by0", 1);
        drain();

        issue(MD_DIVU, 32'd1000, 32'd10, 32'd0, 17, "flushed", 0);
        a = cyc;
        do @(negedge clock); while (cyc < a + 4);
        flush      = 1'b1;
        startValid = 1'b1;
        op         = MD_DIVU;
        #1;
        chk("flush_start_ready", 32'(startReady), 32'd0);
        @(posedge clock);
        #1;
        flush      = 1'b0;
        startValid = 1'b0;
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_valid", 32'(resultValid), 32'd0);
        issue(MD_DIVU, 32'd1000, 32'd10, 32'd100, 17, "after_flush", 1);
        drain();

        resultReady = 1'b0;
        issue(MD_REMU, 32'd100, 32'd7, 32'd2, 17, "hold_remu", 1);
        n = 0;
        while (!resultValid && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk("hold_valid", 32'(resultValid), 32'd1);
        for (int i = 0; i < 3; i++) begin
            startValid = 1'b1;
            op         = MD_DIV;
            operand1   = 32'd7;
            operand2   = 32'hFFFFFFFE;
            #1;
            chk("hold_no_accept", 32'(startReady), 32'd0);
            @(negedge clock);
        end
        resultReady = 1'b1;
        #1;
        chk("b2b_start_ready", 32'(startReady), 32'd1);
        @(posedge clock);
        #1;
        sb.push_back('{32'hFFFFFFFD, 17, cyc, "b2b_div"});
        startValid = 1'b0;
        drain();

        repeat (2) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
